stack_arbiter: RTL and testbench

//   Shares one 8-bit LIFO stack macro (clk, d_in, push, pop, d_out; d_out = current top) between
//   N_REQ requesters. Round-robin arbitration, one stack op per cycle. Keeps a shadow occupancy

---
 rtl/stack_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_stack_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/stack_arbiter.sv
// ---------------------------------------------------------------------------
// stack_arbiter
//   Shares a single LIFO stack macro between N_REQ requesters. A round-robin
//   arbiter picks one request per cycle. The block keeps a shadow occupancy
//   count so that pushes to a full stack and pops from an empty stack are
//   rejected and never reach the macro. It is the only driver of the
//   macro's push/pop strobes.
//
//   Optional feature macro: STACK_ARB_PEEK_EN
//     defined   : a pop with req_peek[i] = 1 is a non-destructive peek
//                 (returns top of stack, no stk_pop, count unchanged).
//     undefined : req_peek is ignored; every pop is destructive.
//
// Ports
//   clk        in   clock, all logic on posedge
//   rst        in   synchronous active-high reset
//   req        in   [N_REQ]     per-requester request, held until granted
//   req_op     in   [N_REQ]     0 = push, 1 = pop
//   req_peek   in   [N_REQ]     peek qualifier (STACK_ARB_PEEK_EN only)
//   req_wdata  in   [DW*N_REQ]  push data, slice i for requester i
//   gnt        out  [N_REQ]     one-hot grant pulse (request consumed)
//   rsp_valid  out  [N_REQ]     one-hot response, the cycle after gnt
//   rsp_err    out              response is a rejection (full push/empty pop)
//   rsp_data   out  [DW]        popped/peeked value, 0 otherwise
//   stk_push   out              stack push strobe
//   stk_pop    out              stack pop strobe
//   stk_din    out  [DW]        stack write data, 0 when not pushing
//   stk_dout   in   [DW]        stack top (combinational from the macro)
//   count      out              shadow occupancy
//   full/empty out              count == DEPTH / count == 0
// ---------------------------------------------------------------------------
module stack_arbiter #(
  parameter int N_REQ = 2,
  parameter int DW    = 8,
  parameter int DEPTH = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            req_op,
  input  logic [N_REQ-1:0]            req_peek,
  input  logic [DW*N_REQ-1:0]         req_wdata,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic                        rsp_err,
  output logic [DW-1:0]               rsp_data,
  output logic                        stk_push,
  output logic                        stk_pop,
  output logic [DW-1:0]               stk_din,
  input  logic [DW-1:0]               stk_dout,
  output logic [$clog2(DEPTH+1)-1:0]  count,
  output logic                        full,
  output logic                        empty
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [IW-1:0] LAST_C  = IW'(N_REQ - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  // Registered state
  state_t             state_q,    state_d;
  logic [IW-1:0]      rr_ptr_q,   rr_ptr_d;
  logic [CW-1:0]      count_q,    count_d;
  logic [N_REQ-1:0]   rsp_vec_q,  rsp_vec_d;
  logic               rsp_err_q,  rsp_err_d;
  logic [DW-1:0]      rsp_data_q, rsp_data_d;

  // Arbitration results
  logic               sel_any;
  logic [IW-1:0]      sel_idx;
  int                 cand;

  // Decoded granted operation
  logic               sel_pop;
  logic               sel_peek;
  logic [DW-1:0]      sel_wdata;
  logic               push_ok;
  logic               pop_ok;
  logic               peek_ok;

`ifndef STACK_ARB_PEEK_EN
  // Peek qualifier has no function in this build.
  logic unused_req_peek;
  assign unused_req_peek = ^req_peek;
`endif

  // Round-robin scan starting at rr_ptr. Scanning the offsets from last to
  // first and overwriting leaves the first requesting index in scan order.
  always_comb begin
    sel_any = 1'b0;
    sel_idx = '0;
    cand    = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = (int'(rr_ptr_q) + k) % N_REQ;
      if (req[cand]) begin
        sel_any = 1'b1;
        sel_idx = IW'(cand);
      end
    end
    // Nothing is granted while reset is asserted, so no strobe reaches the
    // macro and no response is produced.
    if (rst) begin
      sel_any = 1'b0;
    end
  end

  // Decode the granted op and check it against the shadow count.
  always_comb begin
    sel_pop   = req_op[sel_idx];
`ifdef STACK_ARB_PEEK_EN
    sel_peek  = req_op[sel_idx] & req_peek[sel_idx];
`else
    sel_peek  = 1'b0;
`endif
    sel_wdata = req_wdata[sel_idx*DW +: DW];
    push_ok   = sel_any & ~sel_pop & (count_q != DEPTH_C);
    pop_ok    = sel_any & sel_pop & ~sel_peek & (count_q != '0);
    peek_ok   = sel_any & sel_peek & (count_q != '0);
  end

  // Grant and macro strobes, same cycle as the decision.
  always_comb begin
    gnt      = '0;
    stk_push = push_ok;
    stk_pop  = pop_ok;
    stk_din  = push_ok ? sel_wdata : '0;
    if (sel_any) begin
      gnt[sel_idx] = 1'b1;
    end
  end

  // Next-state: FSM, pointer, count and the response captured for next cycle.
  always_comb begin
    state_d    = IDLE;
    rr_ptr_d   = rr_ptr_q;
    count_d    = count_q;
    rsp_vec_d  = '0;
    rsp_err_d  = 1'b0;
    rsp_data_d = '0;

    if (sel_any) begin
      state_d          = RESP;
      rr_ptr_d         = (sel_idx == LAST_C) ? '0 : sel_idx + IW'(1);
      rsp_vec_d[sel_idx] = 1'b1;
      rsp_err_d        = ~(push_ok | pop_ok | peek_ok);
      if (pop_ok || peek_ok) begin
        rsp_data_d = stk_dout;
      end
    end

    // The checks above keep count inside [0, DEPTH]; it never wraps.
    if (push_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  // --- register stage: state, count and response ---
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      count_q    <= '0;
      rsp_vec_q  <= '0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      count_q    <= count_d;
      rsp_vec_q  <= rsp_vec_d;
      rsp_err_q  <= rsp_err_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Response is only presented in RESP; in IDLE the captured fields are
  // already zero, the gating just ties them to the FSM explicitly.
  always_comb begin
    rsp_valid = '0;
    rsp_err   = 1'b0;
    rsp_data  = '0;
    if (state_q == RESP) begin
      rsp_valid = rsp_vec_q;
      rsp_err   = rsp_err_q;
      rsp_data  = rsp_data_q;
    end
  end

  assign count = count_q;
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);

endmodule

// File: tb/tb_stack_arbiter.sv
module tb_stack_arbiter;

  localparam int N_REQ = 2;
  localparam int DW    = 8;
  localparam int DEPTH = 32;

  logic              clk;
  logic              rst;
  logic [N_REQ-1:0]  req;
  logic [N_REQ-1:0]  req_op;
  logic [N_REQ-1:0]  req_peek;
  logic [DW*N_REQ-1:0] req_wdata;
  logic [N_REQ-1:0]  gnt;
  logic [N_REQ-1:0]  rsp_valid;
  logic              rsp_err;
  logic [DW-1:0]     rsp_data;
  logic              stk_push;
  logic              stk_pop;
  logic [DW-1:0]     stk_din;
  logic [DW-1:0]     stk_dout;
  logic [5:0]        count;
  logic              full;
  logic              empty;

  int total;
  int bad;

  stack_arbiter #(.N_REQ(N_REQ), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_peek(req_peek),
    .req_wdata(req_wdata), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_data(rsp_data), .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
    .stk_dout(stk_dout), .count(count), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural stack macro: no reset, relative 5-bit addressing.
  logic [DW-1:0] mem [0:31];
  logic [4:0]    sp;
  initial begin
    sp = 5'd0;
    for (int i = 0; i < 32; i++) mem[i] = '0;
  end
  always @(posedge clk) begin
    if (stk_push) begin
      mem[sp] <= stk_din;
      sp      <= sp + 5'd1;
    end else if (stk_pop) begin
      sp <= sp - 5'd1;
    end
  end
  assign stk_dout = mem[sp - 5'd1];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_req;
    req      = '0;
    req_op   = '0;
    req_peek = '0;
    req_wdata = '0;
  endtask

  task automatic drive(input int i, input logic op, input logic pk, input logic [DW-1:0] d);
    req[i]              = 1'b1;
    req_op[i]           = op;
    req_peek[i]         = pk;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic do_reset;
    clear_req();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    do_reset();
    total++; if (count !== 6'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL reset_flags got empty=%b full=%b want 1 0", empty, full); end
    total++; if (rsp_valid !== 2'b00 || rsp_err !== 1'b0 || rsp_data !== 8'h00) begin bad++; $display("FAIL reset_rsp got v=%b e=%b d=%h want 00 0 00", rsp_valid, rsp_err, rsp_data); end
    total++; if (gnt !== 2'b00 || stk_push !== 1'b0 || stk_pop !== 1'b0 || stk_din !== 8'h00) begin bad++; $display("FAIL reset_strobes got g=%b p=%b o=%b d=%h want 00 0 0 00", gnt, stk_push, stk_pop, stk_din); end
  endtask

  task automatic test_push_pop;
    do_reset();
    drive(0, 1'b0, 1'b0, 8'hA5);
    #1;
    total++; if (gnt !== 2'b01 || stk_push !== 1'b1 || stk_din !== 8'hA5) begin bad++; $display("FAIL pp_push got g=%b p=%b d=%h want 01 1 a5", gnt, stk_push, stk_din); end
    tick();
    drive(0, 1'b1, 1'b0, 8'h00);
    #1;
    total++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_data !== 8'h00) begin bad++; $display("FAIL pp_push_rsp got v=%b e=%b d=%h want 01 0 00", rsp_valid, rsp_err, rsp_data); end
    total++; if (count !== 6'd1) begin bad++; $display("FAIL pp_count1 got=%0d want=1", count); end
    total++; if (gnt !== 2'b01 || stk_pop !== 1'b1 || stk_push !== 1'b0) begin bad++; $display("FAIL pp_pop got g=%b o=%b p=%b want 01 1 0", gnt, stk_pop, stk_push); end
    tick();
    clear_req();
    #1;
    total++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_data !== 8'hA5) begin bad++; $display("FAIL pp_pop_rsp got v=%b e=%b d=%h want 01 0 a5", rsp_valid, rsp_err, rsp_data); end
    total++; if (count !== 6'd0 || empty !== 1'b1) begin bad++; $display("FAIL pp_count0 got=%0d empty=%b want 0 1", count, empty); end
    tick();
    total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL pp_rsp_drop got=%b want=00", rsp_valid); end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_g;
    logic [7:0] exp_d;
    do_reset();
    drive(0, 1'b0, 1'b0, 8'h11);
    drive(1, 1'b0, 1'b0, 8'h22);
    #1;
    for (int c = 0; c < 4; c++) begin
      exp_g = (c % 2 == 0) ? 2'b01 : 2'b10;
      exp_d = (c % 2 == 0) ? 8'h11 : 8'h22;
      total++; if (gnt !== exp_g || stk_push !== 1'b1 || stk_din !== exp_d) begin bad++; $display("FAIL rr_cycle%0d got g=%b p=%b d=%h want %b 1 %h", c, gnt, stk_push, stk_din, exp_g, exp_d); end
      tick();
      #1;
      total++; if (rsp_valid !== exp_g) begin bad++; $display("FAIL rr_rsp%0d got=%b want=%b", c, rsp_valid, exp_g); end
    end
    clear_req();
    #1;
    total++; if (count !== 6'd4) begin bad++; $display("FAIL rr_count got=%0d want=4", count); end
  endtask

  task automatic test_overflow;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(0, 1'b0, 1'b0, 8'(i));
      tick();
    end
    drive(0, 1'b0, 1'b0, 8'hEE);
    #1;
    total++; if (count !== 6'd32 || full !== 1'b1) begin bad++; $display("FAIL ovf_fill got=%0d full=%b want 32 1", count, full); end
    total++; if (gnt !== 2'b01 || stk_push !== 1'b0 || stk_din !== 8'h00) begin bad++; $display("FAIL ovf_gnt got g=%b p=%b d=%h want 01 0 00", gnt, stk_push, stk_din); end
    tick();
    drive(0, 1'b1, 1'b0, 8'h00);
    #1;
    total++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_data !== 8'h00) begin bad++; $display("FAIL ovf_rsp got v=%b e=%b d=%h want 01 1 00", rsp_valid, rsp_err, rsp_data); end
    total++; if (count !== 6'd32 || full !== 1'b1) begin bad++; $display("FAIL ovf_hold got=%0d full=%b want 32 1", count, full); end
    tick();
    clear_req();
    #1;
    total++; if (rsp_data !== 8'd31 || rsp_err !== 1'b0 || count !== 6'd31 || full !== 1'b0) begin bad++; $display("FAIL ovf_top got d=%0d e=%b c=%0d f=%b want 31 0 31 0", rsp_data, rsp_err, count, full); end
  endtask

  task automatic test_underflow;
    do_reset();
    drive(0, 1'b1, 1'b0, 8'h00);
    #1;
    total++; if (gnt !== 2'b01 || stk_pop !== 1'b0) begin bad++; $display("FAIL unf_gnt got g=%b o=%b want 01 0", gnt, stk_pop); end
    tick();
    clear_req();
    #1;
    total++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_data !== 8'h00) begin bad++; $display("FAIL unf_rsp got v=%b e=%b d=%h want 01 1 00", rsp_valid, rsp_err, rsp_data); end
    total++; if (empty !== 1'b1 || count !== 6'd0) begin bad++; $display("FAIL unf_empty got e=%b c=%0d want 1 0", empty, count); end
  endtask

  task automatic test_reset_midstream;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      drive(0, 1'b0, 1'b0, 8'(i));
      tick();
    end
    drive(0, 1'b1, 1'b0, 8'h00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_req();
    #1;
    total++; if (rsp_valid !== 2'b00 || count !== 6'd0) begin bad++; $display("FAIL mid_rst got v=%b c=%0d want 00 0", rsp_valid, count); end
    drive(0, 1'b0, 1'b0, 8'h07);
    tick();
    drive(0, 1'b1, 1'b0, 8'h00);
    tick();
    clear_req();
    #1;
    total++; if (rsp_valid !== 2'b01 || rsp_data !== 8'h07 || rsp_err !== 1'b0 || count !== 6'd0) begin bad++; $display("FAIL mid_pop got v=%b d=%h e=%b c=%0d want 01 07 0 0", rsp_valid, rsp_data, rsp_err, count); end
  endtask

  task automatic test_peek;
    do_reset();
    drive(0, 1'b0, 1'b0, 8'h3C);
    tick();
`ifdef STACK_ARB_PEEK_EN
    for (int p = 0; p < 2; p++) begin
      drive(0, 1'b1, 1'b1, 8'h00);
      #1;
      total++; if (gnt !== 2'b01 || stk_pop !== 1'b0) begin bad++; $display("FAIL peek%0d_strobe got g=%b o=%b want 01 0", p, gnt, stk_pop); end
      tick();
      #1;
      total++; if (rsp_data !== 8'h3C || rsp_err !== 1'b0 || count !== 6'd1) begin bad++; $display("FAIL peek%0d_rsp got d=%h e=%b c=%0d want 3c 0 1", p, rsp_data, rsp_err, count); end
    end
`endif
    drive(0, 1'b1, 1'b1, 8'h00);
`ifdef STACK_ARB_PEEK_EN
    req_peek[0] = 1'b0;
`endif
    #1;
    total++; if (gnt !== 2'b01 || stk_pop !== 1'b1) begin bad++; $display("FAIL peek_pop_strobe got g=%b o=%b want 01 1", gnt, stk_pop); end
    tick();
    clear_req();
    #1;
    total++; if (rsp_data !== 8'h3C || rsp_err !== 1'b0 || count !== 6'd0) begin bad++; $display("FAIL peek_pop_rsp got d=%h e=%b c=%0d want 3c 0 0", rsp_data, rsp_err, count); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    clear_req();
    test_reset();
    test_push_pop();
    test_round_robin();
    test_overflow();
    test_underflow();
    test_reset_midstream();
    test_peek();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
